// File: rtl/cisc_bus_pkg.sv
// Shared definitions for the CISC bus cycle sequencer.
// Contents: the T-state encodings driven to the bus interface unit, the
// cycle-owner encodings, and the sequencer state enum.
// This package has no ports.
package cisc_bus_pkg;

  localparam logic [2:0] T0          = 3'd0;
  localparam logic [2:0] T1          = 3'd1;
  localparam logic [2:0] T2          = 3'd2;
  localparam logic [2:0] T3          = 3'd3;
  localparam logic [2:0] T4          = 3'd4;
  localparam logic [2:0] T5          = 3'd5;
  localparam logic [2:0] T6          = 3'd6;
  localparam logic [2:0] T7          = 3'd7;
  localparam logic [2:0] IDLE_TSTATE = 3'b111;

  localparam logic OWNER_EU    = 1'b1;
  localparam logic OWNER_FETCH = 1'b0;

  // IDLE and T7 both show 3'b111 on the bus, so the state needs a fourth
  // bit to tell them apart.
  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_IDLE = 4'd8
  } bus_state_t;

endpackage

// File: rtl/bus_arbiter_2to1.sv
// Two-way bus arbiter between the execution unit and the prefetch unit.
// The EU has priority. A registered starvation counter forces one fetch
// grant after STARVE_LIMIT back-to-back EU grants while fetch is waiting.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   eu_req     EU bus request
//   fetch_req  prefetch bus request
//   arb_en     high when the sequencer is at an arbitration point
//   eu_win     EU would be granted now (combinational)
//   fetch_win  fetch would be granted now (combinational)
module bus_arbiter_2to1 #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic eu_req,
  input  logic fetch_req,
  input  logic arb_en,
  output logic eu_win,
  output logic fetch_win
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    eu_win    = eu_req && (!fetch_req || (starve_cnt < LIMIT));
    fetch_win = fetch_req && !eu_win;
  end

  // The count only means something while fetch is actually waiting, so a
  // low fetch_req clears it regardless of where the sequencer is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!fetch_req) begin
      starve_cnt <= '0;
    end else if (arb_en && fetch_win) begin
      starve_cnt <= '0;
    end else if (arb_en && eu_win && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Bus cycle sequencer: arbitrates the external bus between the EU and the
// prefetch unit, latches the winner's address/direction and steps the bus
// interface unit through T0..T7, holding T5 while memory is not ready.
// Ports:
//   clk, rst               clock and asynchronous active-high reset
//   eu_req/eu_wr/eu_addr   EU request, direction (1 = write) and address
//   fetch_req/fetch_addr   prefetch read request and address
//   ready                  memory ready, sampled in T5
//   t_state                T-state to the bus interface unit (111 when idle)
//   busint                 bus cycle active
//   dtr_                   cycle direction, 1 = write
//   addr_out               latched cycle address
//   eu_gnt/fetch_gnt       one-cycle grant pulses
//   cycle_done             one-cycle pulse in T7
//   owner                  current cycle owner, 1 = EU
//   bus_err                (BUS_WAIT_TIMEOUT_EN only) pulses with cycle_done
//                          when the cycle was ended by the wait timeout
// Optional feature macro: BUS_WAIT_TIMEOUT_EN bounds T5 wait states to
// TIMEOUT; without it waits are unbounded.
module bus_cycle_sequencer
  import cisc_bus_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 4
`ifdef BUS_WAIT_TIMEOUT_EN
  , parameter int TIMEOUT    = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eu_req,
  input  logic              eu_wr,
  input  logic [ADDR_W-1:0] eu_addr,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              ready,
  output logic [2:0]        t_state,
  output logic              busint,
  output logic              dtr_,
  output logic [ADDR_W-1:0] addr_out,
  output logic              eu_gnt,
  output logic              fetch_gnt,
  output logic              cycle_done,
  output logic              owner
`ifdef BUS_WAIT_TIMEOUT_EN
  , output logic            bus_err
`endif
);

  bus_state_t state, next_state;
  logic       arb_en;
  logic       eu_win, fetch_win;
  logic       grant;
  logic       wait_expired;

  // Arbitration happens in IDLE and in T7 so back-to-back cycles need no
  // idle cycle between them.
  assign arb_en = (state == S_IDLE) || (state == S_T7);
  assign grant  = arb_en && (eu_win || fetch_win);

  bus_arbiter_2to1 #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .eu_req    (eu_req),
    .fetch_req (fetch_req),
    .arb_en    (arb_en),
    .eu_win    (eu_win),
    .fetch_win (fetch_win)
  );

`ifdef BUS_WAIT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timed_out;

  assign wait_expired = (wait_cnt == WAIT_MAX);

  // timed_out remembers that this cycle was cut short so bus_err can be
  // flagged later, at T7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else if (state == S_T0) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else if ((state == S_T5) && !ready) begin
      if (wait_expired) begin
        timed_out <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign bus_err = cycle_done && timed_out;
`else
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (grant) next_state = S_T0;
      S_T0:   next_state = S_T1;
      S_T1:   next_state = S_T2;
      S_T2:   next_state = S_T3;
      S_T3:   next_state = S_T4;
      S_T4:   next_state = S_T5;
      S_T5:   if (ready || wait_expired) next_state = S_T6;
      S_T6:   next_state = S_T7;
      S_T7:   next_state = grant ? S_T0 : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Grants are gated by rst so a pending request is not acknowledged while
  // the sequencer is being held in reset.
  always_comb begin
    t_state = IDLE_TSTATE;
    case (state)
      S_T0: t_state = T0;
      S_T1: t_state = T1;
      S_T2: t_state = T2;
      S_T3: t_state = T3;
      S_T4: t_state = T4;
      S_T5: t_state = T5;
      S_T6: t_state = T6;
      S_T7: t_state = T7;
      default: t_state = IDLE_TSTATE;
    endcase
    busint     = (state != S_IDLE);
    cycle_done = (state == S_T7);
    eu_gnt     = arb_en && eu_win && !rst;
    fetch_gnt  = arb_en && fetch_win && !rst;
  end

  // Cycle attributes are only loaded at a grant, which keeps them stable
  // from T0 through T7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_out <= '0;
      owner    <= OWNER_FETCH;
      dtr_     <= 1'b0;
    end else if (grant) begin
      if (eu_win) begin
        addr_out <= eu_addr;
        owner    <= OWNER_EU;
        dtr_     <= eu_wr;
      end else begin
        addr_out <= fetch_addr;
        owner    <= OWNER_FETCH;
        dtr_     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed testbench for bus_cycle_sequencer (default parameters).
// Covers reset values, a plain EU read, a write with wait states, EU/fetch
// contention with starvation relief, reset in mid-cycle and a late request.
// With BUS_WAIT_TIMEOUT_EN defined it also exercises the wait timeout.
module tb_bus_cycle_sequencer;

  logic        clk;
  logic        rst;
  logic        eu_req;
  logic        eu_wr;
  logic [15:0] eu_addr;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        ready;
  logic [2:0]  t_state;
  logic        busint;
  logic        dtr_;
  logic [15:0] addr_out;
  logic        eu_gnt;
  logic        fetch_gnt;
  logic        cycle_done;
  logic        owner;
`ifdef BUS_WAIT_TIMEOUT_EN
  logic        bus_err;
`endif

  int checks;
  int errors;

  bus_cycle_sequencer #(
    .ADDR_W(16),
    .STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .eu_req     (eu_req),
    .eu_wr      (eu_wr),
    .eu_addr    (eu_addr),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .ready      (ready),
    .t_state    (t_state),
    .busint     (busint),
    .dtr_       (dtr_),
    .addr_out   (addr_out),
    .eu_gnt     (eu_gnt),
    .fetch_gnt  (fetch_gnt),
    .cycle_done (cycle_done),
    .owner      (owner)
`ifdef BUS_WAIT_TIMEOUT_EN
    , .bus_err  (bus_err)
`endif
  );

  // Rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic er, input logic ew, input logic [15:0] ea,
                               input logic fr, input logic [15:0] fa, input logic rdy);
    eu_req     = er;
    eu_wr      = ew;
    eu_addr    = ea;
    fetch_req  = fr;
    fetch_addr = fa;
    ready      = rdy;
  endtask

  // Move to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (busint == 1'b0) break;
      tick();
    end
    checkOutput(tag, {31'd0, busint}, 32'd0);
  endtask

  initial begin
    int n5;
    int total;
    int done_cnt;
    int dtr_bad;
    int gcount;
    int order [6];
    int gcyc [6];
    int exp_order [6];

    checks = 0;
    errors = 0;
    exp_order = '{1, 1, 1, 1, 0, 1};

    // ---------------- reset values ----------------
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    tick();
    tick();
    checkOutput("rst_tstate", {29'd0, t_state}, 32'd7);
    checkOutput("rst_busint", {31'd0, busint}, 32'd0);
    checkOutput("rst_dtr", {31'd0, dtr_}, 32'd0);
    checkOutput("rst_addr", {16'd0, addr_out}, 32'd0);
    checkOutput("rst_owner", {31'd0, owner}, 32'd0);
    checkOutput("rst_gnts", {30'd0, eu_gnt, fetch_gnt}, 32'd0);
    checkOutput("rst_done", {31'd0, cycle_done}, 32'd0);
    rst = 1'b0;
    tick();

    // ---------------- single EU read ----------------
    applyStimulus(1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b1);
    #1;
    checkOutput("rd_eu_gnt", {31'd0, eu_gnt}, 32'd1);
    checkOutput("rd_fetch_gnt", {31'd0, fetch_gnt}, 32'd0);
    checkOutput("rd_idle_tstate", {29'd0, t_state}, 32'd7);
    tick();
    eu_req = 1'b0;
    checkOutput("rd_gnt_pulse", {31'd0, eu_gnt}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("rd_tstate_%0d", i), {29'd0, t_state}, i);
      checkOutput($sformatf("rd_busint_%0d", i), {31'd0, busint}, 32'd1);
      checkOutput($sformatf("rd_dtr_%0d", i), {31'd0, dtr_}, 32'd0);
      checkOutput($sformatf("rd_addr_%0d", i), {16'd0, addr_out}, 32'h1234);
      checkOutput($sformatf("rd_owner_%0d", i), {31'd0, owner}, 32'd1);
      checkOutput($sformatf("rd_done_%0d", i), {31'd0, cycle_done}, (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    checkOutput("rd_after_tstate", {29'd0, t_state}, 32'd7);
    checkOutput("rd_after_busint", {31'd0, busint}, 32'd0);
    checkOutput("rd_after_done", {31'd0, cycle_done}, 32'd0);

    // ---------------- EU write with 3 wait states ----------------
    applyStimulus(1'b1, 1'b1, 16'h00FF, 1'b0, 16'h0000, 1'b1);
    tick();
    eu_req   = 1'b0;
    n5       = 0;
    total    = 0;
    done_cnt = 0;
    dtr_bad  = 0;
    for (int c = 0; c < 40; c++) begin
      if (busint == 1'b0) break;
      total++;
      if (dtr_ !== 1'b1) dtr_bad++;
      if (cycle_done) done_cnt++;
      if (t_state == 3'd5) begin
        ready = (n5 >= 3);
        n5++;
      end
      tick();
    end
    ready = 1'b1;
    checkOutput("ws_t5_clocks", n5, 32'd4);
    checkOutput("ws_total_clocks", total, 32'd11);
    checkOutput("ws_dtr_write", dtr_bad, 32'd0);
    checkOutput("ws_done_count", done_cnt, 32'd1);
    checkOutput("ws_addr", {16'd0, addr_out}, 32'h00FF);

    // ---------------- contention and starvation relief ----------------
    applyStimulus(1'b1, 1'b0, 16'h2000, 1'b1, 16'h8000, 1'b1);
    gcount = 0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (eu_gnt || fetch_gnt) begin
        order[gcount] = eu_gnt ? 1 : 0;
        gcyc[gcount]  = c;
        gcount++;
      end
      if (gcount >= 6) break;
      tick();
    end
    checkOutput("arb_grant_count", gcount, 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < gcount) begin
        checkOutput($sformatf("arb_order_%0d", k), order[k], exp_order[k]);
        checkOutput($sformatf("arb_cycle_%0d", k), gcyc[k], 8 * k);
      end
    end
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    checkOutput("arb_last_owner", {31'd0, owner}, 32'd1);
    waitIdle("arb_idle");

    // ---------------- reset during a fetch cycle ----------------
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4321, 1'b1);
    #1;
    checkOutput("rr_fetch_gnt", {31'd0, fetch_gnt}, 32'd1);
    tick();
    tick();
    tick();
    tick();
    checkOutput("rr_at_t3", {29'd0, t_state}, 32'd3);
    checkOutput("rr_fetch_addr", {16'd0, addr_out}, 32'h4321);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rr_async_tstate", {29'd0, t_state}, 32'd7);
    checkOutput("rr_async_busint", {31'd0, busint}, 32'd0);
    checkOutput("rr_async_addr", {16'd0, addr_out}, 32'd0);
    checkOutput("rr_async_done", {31'd0, cycle_done}, 32'd0);
    checkOutput("rr_held_gnt", {31'd0, fetch_gnt}, 32'd0);
    tick();
    checkOutput("rr_held_done", {31'd0, cycle_done}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rr_regrant", {31'd0, fetch_gnt}, 32'd1);
    tick();
    fetch_req = 1'b0;
    checkOutput("rr_t0", {29'd0, t_state}, 32'd0);
    checkOutput("rr_t0_addr", {16'd0, addr_out}, 32'h4321);
    checkOutput("rr_t0_owner", {31'd0, owner}, 32'd0);
    checkOutput("rr_t0_dtr", {31'd0, dtr_}, 32'd0);
    waitIdle("rr_idle");

    // ---------------- late fetch request during an EU cycle ----------------
    applyStimulus(1'b1, 1'b1, 16'h5555, 1'b0, 16'h0000, 1'b1);
    tick();
    eu_req = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checkOutput("late_at_t4", {29'd0, t_state}, 32'd4);
    fetch_req  = 1'b1;
    fetch_addr = 16'hABCD;
    #1;
    checkOutput("late_t4_gnt", {31'd0, fetch_gnt}, 32'd0);
    tick();
    checkOutput("late_t5_gnt", {31'd0, fetch_gnt}, 32'd0);
    tick();
    checkOutput("late_t6_gnt", {31'd0, fetch_gnt}, 32'd0);
    checkOutput("late_t6_addr", {16'd0, addr_out}, 32'h5555);
    tick();
    checkOutput("late_t7_tstate", {29'd0, t_state}, 32'd7);
    checkOutput("late_t7_gnt", {31'd0, fetch_gnt}, 32'd1);
    checkOutput("late_t7_done", {31'd0, cycle_done}, 32'd1);
    tick();
    fetch_req = 1'b0;
    checkOutput("late_next_t0", {29'd0, t_state}, 32'd0);
    checkOutput("late_next_busint", {31'd0, busint}, 32'd1);
    checkOutput("late_next_addr", {16'd0, addr_out}, 32'hABCD);
    checkOutput("late_next_owner", {31'd0, owner}, 32'd0);
    checkOutput("late_next_dtr", {31'd0, dtr_}, 32'd0);
    waitIdle("late_idle");

`ifdef BUS_WAIT_TIMEOUT_EN
    // ---------------- wait timeout with ready stuck low ----------------
    applyStimulus(1'b1, 1'b0, 16'h0F0F, 1'b0, 16'h0000, 1'b0);
    tick();
    eu_req   = 1'b0;
    n5       = 0;
    done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (busint == 1'b0) break;
      if (t_state == 3'd5) n5++;
      if (cycle_done) begin
        done_cnt++;
        checkOutput("to_bus_err", {31'd0, bus_err}, 32'd1);
      end else begin
        checkOutput("to_bus_err_quiet", {31'd0, bus_err}, 32'd0);
      end
      tick();
    end
    ready = 1'b1;
    checkOutput("to_t5_clocks", n5, 32'd16);
    checkOutput("to_done_count", done_cnt, 32'd1);
    checkOutput("to_idle_busint", {31'd0, busint}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
